// File: rtl/ofs_fim_pcie_ss_ib2sb.sv
// RX-path converter from in-band-header PCIe SS TLP streams to side-band-header streams.
// The header is moved onto tuser_vendor and the payload is re-packed so that it starts at tdata bit 0.
module ofs_fim_pcie_ss_ib2sb #(
   parameter int DATA_W = 512,
   parameter int HDR_W  = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_tvalid,
   output logic                in_tready,
   input  logic [DATA_W-1:0]   in_tdata,
   input  logic [DATA_W/8-1:0] in_tkeep,
   input  logic                in_tlast,
   input  logic                in_tuser_vendor,
   output logic                out_tvalid,
   input  logic                out_tready,
   output logic [DATA_W-1:0]   out_tdata,
   output logic [DATA_W/8-1:0] out_tkeep,
   output logic                out_tlast,
   output logic [HDR_W:0]      out_tuser_vendor
);

   localparam int KW = DATA_W / 8;
   localparam int R  = DATA_W - HDR_W;
   localparam int RB = R / 8;
   localparam int HB = HDR_W / 8;

   // The residue is the upper part of the previous beat, still waiting for its output slot.
   logic             held, flush, first, dm;
   logic [HDR_W-1:0] hdr;
   logic [R-1:0]     rdata;
   logic [RB-1:0]    rkeep;

   logic             adv, accept;
   logic [HDR_W-1:0] hdr_sel;
   logic [RB-1:0]    in_upper_keep;

   logic              nx_valid, nx_last, nx_held, nx_flush, nx_first, nx_dm;
   logic [DATA_W-1:0] nx_tdata;
   logic [KW-1:0]     nx_tkeep;
   logic [HDR_W:0]    nx_tuser;
   logic [HDR_W-1:0]  nx_hdr;
   logic [R-1:0]      nx_rdata;
   logic [RB-1:0]     nx_rkeep;

   assign adv           = !out_tvalid || out_tready;
   assign in_tready     = adv && !flush;
   assign accept        = in_tvalid && in_tready;
   assign hdr_sel       = first ? hdr : '0;
   assign in_upper_keep = in_tkeep[KW-1:HB];

   // Next values assume the output stage advances; the registers below only load when adv is high.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      nx_valid = out_tvalid;
      nx_last  = out_tlast;
      nx_tdata = out_tdata;
      nx_tkeep = out_tkeep;
      nx_tuser = out_tuser_vendor;
      nx_held  = held;
      nx_flush = flush;
      nx_first = first;
      nx_dm    = dm;
      nx_hdr   = hdr;
      nx_rdata = rdata;
      nx_rkeep = rkeep;

      if (flush) begin
         nx_valid = 1'b1;
         nx_tdata = {{HDR_W{1'b0}}, rdata};
         nx_tkeep = {{HB{1'b0}}, rkeep};
         nx_last  = 1'b1;
         nx_tuser = {hdr_sel, dm};
         nx_held  = 1'b0;
         nx_flush = 1'b0;
      end else if (accept && !held) begin
         nx_hdr = in_tdata[HDR_W-1:0];
         nx_dm  = in_tuser_vendor;
         if (in_tlast) begin
            nx_valid = 1'b1;
            nx_tdata = in_tdata >> HDR_W;
            nx_tkeep = in_tkeep >> HB;
            nx_last  = 1'b1;
            nx_tuser = {in_tdata[HDR_W-1:0], in_tuser_vendor};
         end else begin
            nx_valid = 1'b0;
            nx_rdata = in_tdata[DATA_W-1:HDR_W];
            nx_rkeep = in_upper_keep;
            nx_held  = 1'b1;
            nx_first = 1'b1;
         end
      end else if (accept) begin
         nx_valid = 1'b1;
         nx_tdata = {in_tdata[HDR_W-1:0], rdata};
         nx_tkeep = {in_tkeep[HB-1:0], rkeep};
         nx_tuser = {hdr_sel, dm};
         nx_first = 1'b0;
         nx_rdata = in_tdata[DATA_W-1:HDR_W];
         nx_rkeep = in_upper_keep;
         nx_last  = 1'b0;
         if (in_tlast && in_upper_keep == '0) begin
            nx_last = 1'b1;
            nx_held = 1'b0;
         end else if (in_tlast) begin
            nx_flush = 1'b1;
         end
      end else begin
         nx_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_tvalid       <= 1'b0;
         out_tlast        <= 1'b0;
         out_tkeep        <= '0;
         out_tuser_vendor <= '0;
         held             <= 1'b0;
         flush            <= 1'b0;
         first            <= 1'b0;
      end else if (adv) begin
         out_tvalid       <= nx_valid;
         out_tlast        <= nx_last;
         out_tkeep        <= nx_tkeep;
         out_tuser_vendor <= nx_tuser;
         held             <= nx_held;
         flush            <= nx_flush;
         first            <= nx_first;
      end
   end

   // NOTE: wide datapath registers are left unreset; they are only observed while the reset control state marks them meaningful.
   always_ff @(posedge clk) begin
      if (adv) begin
         out_tdata <= nx_tdata;
         hdr       <= nx_hdr;
         dm        <= nx_dm;
         rdata     <= nx_rdata;
         rkeep     <= nx_rkeep;
      end
   end

endmodule

// File: tb/tb_ofs_fim_pcie_ss_ib2sb.sv
// Scoreboard bench for ofs_fim_pcie_ss_ib2sb: TLPs are modelled as header + payload byte lists,
// and the expected side-band beats are derived by chunking the payload into 64-byte groups.
module tb_ofs_fim_pcie_ss_ib2sb;

   localparam int DATA_W = 512;
   localparam int HDR_W  = 256;
   localparam int KW     = DATA_W / 8;
   localparam int HB     = HDR_W / 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_tvalid = 1'b0;
   logic              in_tready;
   logic [DATA_W-1:0] in_tdata = '0;
   logic [KW-1:0]     in_tkeep = '0;
   logic              in_tlast = 1'b0;
   logic              in_tuser_vendor = 1'b0;
   logic              out_tvalid;
   logic              out_tready = 1'b1;
   logic [DATA_W-1:0] out_tdata;
   logic [KW-1:0]     out_tkeep;
   logic              out_tlast;
   logic [HDR_W:0]    out_tuser_vendor;

   typedef struct packed {
      logic [DATA_W-1:0] tdata;
      logic [KW-1:0]     tkeep;
      logic              tlast;
      logic [HDR_W:0]    tuser;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    ready_mode = 1;   // 0 random backpressure, 1 always ready, 2 never ready

   ofs_fim_pcie_ss_ib2sb #(.DATA_W(DATA_W), .HDR_W(HDR_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_tvalid        (in_tvalid),
      .in_tready        (in_tready),
      .in_tdata         (in_tdata),
      .in_tkeep         (in_tkeep),
      .in_tlast         (in_tlast),
      .in_tuser_vendor  (in_tuser_vendor),
      .out_tvalid       (out_tvalid),
      .out_tready       (out_tready),
      .out_tdata        (out_tdata),
      .out_tkeep        (out_tkeep),
      .out_tlast        (out_tlast),
      .out_tuser_vendor (out_tuser_vendor)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_tready = ($urandom_range(0, 15) != 0);
            1:       out_tready = 1'b1;
            default: out_tready = 1'b0;
         endcase
      end
   end

   // Monitor: a transfer happens on the next edge when valid && ready are seen here.
   always @(negedge clk) begin
      if (rst_n && out_tvalid && out_tready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {{(DATA_W-1){1'b0}}, out_tvalid}, '0);
         end else begin
            beat_t e;
            logic [DATA_W-1:0] mask;
            e = exp_q.pop_front();
            mask = '0;
            for (int k = 0; k < KW; k++) if (e.tkeep[k]) mask[8*k +: 8] = 8'hFF;
            check("tdata", out_tdata & mask, e.tdata);
            check("tkeep", out_tkeep, e.tkeep);
            check("tlast", out_tlast, e.tlast);
            check("tuser", out_tuser_vendor, e.tuser);
         end
      end
   end

   task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KW-1:0] k, input logic l, input logic u);
      bit ok;
      in_tvalid = 1'b1;
      in_tdata = d;
      in_tkeep = k;
      in_tlast = l;
      in_tuser_vendor = u;
      ok = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (in_tready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      check("accept_timeout", ok, 1);
   endtask

   task automatic send_tlp(input int n, input bit chk_flush, input bit gaps);
      logic [HDR_W-1:0]  hdr;
      logic              dm;
      logic [7:0]        pl[$];
      logic [DATA_W-1:0] d;
      logic [KW-1:0]     k;
      int                idx, nbeats;
      beat_t             e;
      for (int i = 0; i < HDR_W / 32; i++) hdr[32*i +: 32] = $urandom();
      dm = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom()));

      // Expected side-band beats: payload in 64-byte chunks, header only on the first.
      nbeats = (n == 0) ? 1 : (n + KW - 1) / KW;
      for (int b = 0; b < nbeats; b++) begin
         e = '0;
         for (int j = 0; j < KW; j++) begin
            if (b * KW + j < n) begin
               e.tdata[8*j +: 8] = pl[b * KW + j];
               e.tkeep[j] = 1'b1;
            end
         end
         e.tlast = (b == nbeats - 1);
         e.tuser = (b == 0) ? {hdr, dm} : {{HDR_W{1'b0}}, dm};
         exp_q.push_back(e);
      end

      // In-band beats: header plus up to 32 payload bytes, then 64-byte beats; junk beyond tkeep.
      idx = 0;
      d = rnd_data();
      d[HDR_W-1:0] = hdr;
      k = '0;
      k[HB-1:0] = '1;
      for (int j = 0; j < HB && idx < n; j++) begin
         d[HDR_W + 8*j +: 8] = pl[idx];
         k[HB + j] = 1'b1;
         idx++;
      end
      send_beat(d, k, idx == n, dm);
      while (idx < n) begin
         if (gaps && $urandom_range(0, 7) == 0) begin
            in_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         d = rnd_data();
         k = '0;
         for (int j = 0; j < KW && idx < n; j++) begin
            d[8*j +: 8] = pl[idx];
            k[j] = 1'b1;
            idx++;
         end
         send_beat(d, k, idx == n, dm);
      end
      if (chk_flush) begin
         @(negedge clk);
         check("flush_in_tready", in_tready, 0);
         @(posedge clk);
         #1;
      end
      if (gaps && $urandom_range(0, 7) == 0) begin
         in_tvalid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      in_tvalid = 1'b0;
      while (exp_q.size() != 0 && t < 4000) begin
         @(posedge clk);
         t++;
      end
      check("drain_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      logic [HDR_W-1:0]  h;
      int                n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", out_tvalid, 0);
      check("rst_tlast", out_tlast, 0);
      check("rst_tkeep", out_tkeep, 0);
      check("rst_tuser", out_tuser_vendor, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed boundary cases with the sink always ready.
      send_tlp(0, 1'b0, 1'b0);
      send_tlp(16, 1'b0, 1'b0);
      send_tlp(64, 1'b0, 1'b0);
      send_tlp(96, 1'b1, 1'b0);
      send_tlp(32, 1'b0, 1'b0);
      send_tlp(33, 1'b0, 1'b0);
      drain();

      // Random back-to-back traffic with occasional backpressure and idle gaps.
      ready_mode = 0;
      for (int i = 0; i < 10000; i++) begin
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 200));
         send_tlp(n, 1'b0, 1'b1);
      end
      drain();

      // Reset in the middle of a TLP while an output beat is stalled.
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < HDR_W / 32; i++) h[32*i +: 32] = $urandom();
      d = rnd_data();
      d[HDR_W-1:0] = h;
      send_beat(d, '1, 1'b0, 1'b1);
      send_beat(rnd_data(), '1, 1'b0, 1'b1);
      in_tvalid = 1'b0;
      @(negedge clk);
      check("pre_rst_tvalid", out_tvalid, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_rst_tvalid", out_tvalid, 0);
      check("mid_rst_in_tready", in_tready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_mode = 0;
      send_tlp(0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) send_tlp(int'($urandom_range(0, 200)), 1'b0, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
